// File: rtl/if_pc_fetch.sv
// Instruction-fetch control stage: program counter, next-PC selection and the IF/ID latch.
// Optional single-step gating is enabled by defining IF_STEP_MODE_EN (adds the Step input).
module if_pc_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter logic [31:0] PC_STEP    = 32'd4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
`ifdef IF_STEP_MODE_EN
  input  logic        Step,
`endif
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JumpTaken,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] PCPlus4In,
  input  logic [31:0] InstrIn,
  output logic [31:0] PCOut,
  output logic [31:0] AdderB,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        Halted,
  output logic [31:0] FetchCount
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        advance_s;
  logic        is_halt_s;

`ifdef IF_STEP_MODE_EN
  assign advance_s = Step;
`else
  assign advance_s = 1'b1;
`endif

  assign is_halt_s = (InstrIn == HALT_INSTR);

  // Next-state selection: redirect beats stall, and a halt word only counts on a clean fetch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    count_d  = count_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    case (state_q)
      S_IDLE: begin
        valid_d  = 1'b0;
        halted_d = 1'b0;
        if (Start) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!advance_s) begin
          state_d = S_RUN;
        end else if (JumpTaken || BranchTaken) begin
          pc_d    = JumpTaken ? JumpTarget : BranchTarget;
          instr_d = 32'd0;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
        end else if (Stall) begin
          state_d = S_RUN;
        end else begin
          instr_d = InstrIn;
          pc4_d   = PCPlus4In;
          valid_d = 1'b1;
          count_d = count_q + 32'd1;
          if (is_halt_s) begin
            state_d  = S_HALTED;
            halted_d = 1'b1;
          end else begin
            pc_d = PCPlus4In;
          end
        end
      end
      S_HALTED: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end
      default: begin
        state_d  = S_IDLE;
        valid_d  = 1'b0;
        halted_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      pc4_q    <= 32'd0;
      count_q  <= 32'd0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign PCOut        = pc_q;
  assign AdderB       = PC_STEP;
  assign IFID_Instr   = instr_q;
  assign IFID_PCPlus4 = pc4_q;
  assign IFID_Valid   = valid_q;
  assign Halted       = halted_q;
  assign FetchCount   = count_q;

endmodule

// File: tb/tb_if_pc_fetch.sv
// Self-checking bench for if_pc_fetch: directed scenarios plus randomized control against a reference model.
// Exercises Step gating when IF_STEP_MODE_EN is defined.
module tb_if_pc_fetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] CONST_WORD = 32'h2000_0001;

  logic        clk;
  logic        rst, start, stall, br, jp, step_in;
  logic [31:0] bt, jt, pc4_in, instr_in;
  logic [31:0] pc_out, adder_b, ifid_instr, ifid_pc4, fetch_count;
  logic        ifid_valid, halted;

  logic        mem_hash;
  logic        halt_en;
  logic [31:0] halt_addr;

  int checks = 0;
  int failures = 0;

  // Reference model: running/halted flags plus the architectural view of the latch.
  logic        m_running, m_halted, m_valid;
  logic [31:0] m_pc, m_instr, m_pc4, m_count;

  function automatic logic [31:0] imem_word(input logic [31:0] a, input logic hash_mode,
                                            input logic hen, input logic [31:0] haddr);
    if (hen && a == haddr) return HALT;
    if (!hash_mode) return CONST_WORD;
    return ((a * 32'h9E37_79B1) ^ 32'h1357_2468) & 32'h7FFF_FFFF;
  endfunction

  assign instr_in = imem_word(pc_out, mem_hash, halt_en, halt_addr);
  assign pc4_in   = pc_out + adder_b;

  if_pc_fetch dut (
    .Clk(clk), .Reset(rst), .Start(start),
`ifdef IF_STEP_MODE_EN
    .Step(step_in),
`endif
    .Stall(stall), .BranchTaken(br), .BranchTarget(bt), .JumpTaken(jp), .JumpTarget(jt),
    .PCPlus4In(pc4_in), .InstrIn(instr_in), .PCOut(pc_out), .AdderB(adder_b),
    .IFID_Instr(ifid_instr), .IFID_PCPlus4(ifid_pc4), .IFID_Valid(ifid_valid),
    .Halted(halted), .FetchCount(fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] word;
    logic        step_ok;
`ifdef IF_STEP_MODE_EN
    step_ok = step_in;
`else
    step_ok = 1'b1;
`endif
    if (rst) begin
      m_running = 1'b0; m_halted = 1'b0; m_valid = 1'b0;
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_count = 32'h0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (!m_running) begin
      m_valid = 1'b0;
      if (start) begin
        m_running = 1'b1;
        m_pc = 32'h0;
      end
    end else if (step_ok) begin
      if (jp || br) begin
        m_pc = jp ? jt : bt;
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (!stall) begin
        word = imem_word(m_pc, mem_hash, halt_en, halt_addr);
        m_instr = word;
        m_pc4 = m_pc + 32'd4;
        m_valid = 1'b1;
        m_count = m_count + 32'd1;
        if (word == HALT) begin
          m_running = 1'b0;
          m_halted = 1'b1;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("pc", pc_out, m_pc);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pc4", ifid_pc4, m_pc4);
    chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("fetch_count", fetch_count, m_count);
    chk("adder_b", adder_b, 32'd4);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; start = 1'b0; stall = 1'b0; br = 1'b0; jp = 1'b0; step_in = 1'b1;
    bt = 32'h0; jt = 32'h0;
  endtask

  initial begin
    idle_inputs();
    mem_hash = 1'b0; halt_en = 1'b0; halt_addr = 32'h0;
    m_running = 1'b0; m_halted = 1'b0; m_valid = 1'b0;
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_count = 32'h0;
    #2;

    // Reset state
    rst = 1'b1; tick(); tick();
    chk("reset_pc", pc_out, 32'h0);
    chk("reset_valid", {31'd0, ifid_valid}, 32'd0);
    rst = 1'b0; tick();
    chk("idle_hold_pc", pc_out, 32'h0);

    // Start and sequential fetch
    start = 1'b1; tick(); start = 1'b0;
    chk("start_pc", pc_out, 32'h0);
    tick();
    chk("seq_pc1", pc_out, 32'h4);
    chk("seq_valid1", {31'd0, ifid_valid}, 32'd1);
    chk("seq_pc4_1", ifid_pc4, 32'h4);
    tick();
    chk("seq_pc2", pc_out, 32'h8);
    chk("seq_pc4_2", ifid_pc4, 32'h8);

    // Stall at PC=8 for two cycles
    stall = 1'b1; tick(); tick(); stall = 1'b0;
    chk("stall_pc", pc_out, 32'h8);
    chk("stall_pc4", ifid_pc4, 32'h8);
    chk("stall_count", fetch_count, 32'd2);
    tick();
    chk("resume_pc", pc_out, 32'hC);
    chk("resume_count", fetch_count, 32'd3);

    // Branch with simultaneous stall: flush wins
    mem_hash = 1'b1;
    br = 1'b1; bt = 32'h40; stall = 1'b1; tick(); br = 1'b0; stall = 1'b0;
    chk("branch_pc", pc_out, 32'h40);
    chk("branch_flush", {31'd0, ifid_valid}, 32'd0);
    tick();
    chk("branch_instr", ifid_instr, imem_word(32'h40, 1'b1, 1'b0, 32'h0));
    chk("branch_pc4", ifid_pc4, 32'h44);

    // Jump and branch together: jump wins
    jp = 1'b1; jt = 32'h100; br = 1'b1; bt = 32'h40; tick(); jp = 1'b0; br = 1'b0;
    chk("jump_wins", pc_out, 32'h100);

    // PC wrap through the adder
    jp = 1'b1; jt = 32'hFFFF_FFFC; tick(); jp = 1'b0;
    tick();
    chk("wrap_pc", pc_out, 32'h0);
    chk("wrap_pc4", ifid_pc4, 32'h0);

    // Randomized control against the model
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(63) == 0);
      start = ($urandom_range(7) == 0);
      stall = ($urandom_range(3) == 0);
      br    = ($urandom_range(7) == 0);
      jp    = ($urandom_range(11) == 0);
      bt    = $urandom() & 32'hFFFF_FFFC;
      jt    = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : $urandom();
`ifdef IF_STEP_MODE_EN
      step_in = ($urandom_range(1) == 0);
`endif
      tick();
    end
    idle_inputs();

    // Reset while running with a simultaneous jump
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    rst = 1'b1; jp = 1'b1; jt = 32'h200; stall = 1'b1; tick();
    idle_inputs();
    chk("midreset_pc", pc_out, 32'h0);
    chk("midreset_count", fetch_count, 32'h0);
    chk("midreset_valid", {31'd0, ifid_valid}, 32'd0);

    // Halt word at 0x10, with a stall cycle on it first
    mem_hash = 1'b0; halt_en = 1'b1; halt_addr = 32'h10;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("halt_reach_pc", pc_out, 32'h10);
    stall = 1'b1; tick(); stall = 1'b0;
    chk("halt_stall_ignored", {31'd0, halted}, 32'd0);
    tick();
    chk("halt_instr", ifid_instr, HALT);
    chk("halt_valid", {31'd0, ifid_valid}, 32'd1);
    chk("halt_pc", pc_out, 32'h10);
    chk("halt_count", fetch_count, 32'd5);
    tick();
    chk("halted_flag", {31'd0, halted}, 32'd1);
    chk("halted_valid", {31'd0, ifid_valid}, 32'd0);
    start = 1'b1; jp = 1'b1; jt = 32'h80; tick(); start = 1'b0; jp = 1'b0;
    chk("halted_start_ignored", pc_out, 32'h10);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("halt_reset_pc", pc_out, 32'h0);
    chk("halt_reset_flag", {31'd0, halted}, 32'd0);
    tick();
    chk("halt_reset_idle", pc_out, 32'h0);
    halt_en = 1'b0;

`ifdef IF_STEP_MODE_EN
    // One PC increment per Step pulse
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step_in = (i % 3 == 0);
      tick();
    end
    step_in = 1'b1;
    chk("step_pc", pc_out, 32'hC);
    chk("step_count", fetch_count, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_pc_fetch.md
Name: if_pc_fetch

Overview:
- Instruction-fetch control stage of the tp3 MIPS pipeline: owns the program counter register and the IF/ID latch.
- Drives the current PC to instruction memory and to the PC+4 adder; the adder is fed PCOut on A and 32'd4 on B.
- Consumes the adder's sum as PCPlus4In and selects the next PC from sequential, branch or jump sources.
- Handles stall, flush, run/halt control and a halt-instruction detector.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset and on Start from IDLE.
- HALT_INSTR, 32'hFFFF_FFFF, instruction word that stops fetch.
- PC_STEP, 32'd4, constant this block provides to the adder's B operand.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Start  input  1  leave IDLE and begin fetching
- Stall  input  1  hazard-unit stall; hold PC and the IF/ID latch
- BranchTaken  input  1  branch resolved taken this cycle
- BranchTarget  input  32  branch destination address
- JumpTaken  input  1  jump resolved this cycle
- JumpTarget  input  32  jump destination address
- PCPlus4In  input  32  adder result, equal to PCOut + PC_STEP
- InstrIn  input  32  instruction memory read data at PCOut (combinational read)
- PCOut  output  32  current PC; goes to IMEM and to adder A
- AdderB  output  32  constant PC_STEP; goes to adder B
- IFID_Instr  output  32  latched instruction
- IFID_PCPlus4  output  32  latched PC+4
- IFID_Valid  output  1  latch holds a real instruction (0 = bubble)
- Halted  output  1  block is in HALTED
- FetchCount  output  32  number of instructions latched valid since reset

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high and takes priority over all other inputs.
- Reset values:
  - PCOut = RESET_PC
  - IFID_Instr = 0, IFID_PCPlus4 = 0, IFID_Valid = 0
  - Halted = 0, FetchCount = 0
  - state = IDLE
- States:
  - IDLE: PC and latch hold, IFID_Valid = 0. Start=1 moves to RUN on the next edge, with PC = RESET_PC.
  - RUN: one fetch per cycle.
  - HALTED: PC frozen, IFID_Valid = 0, Halted = 1. Only Reset leaves this state.
- RUN next-PC priority (highest first): JumpTaken -> JumpTarget; BranchTaken -> BranchTarget; Stall -> hold PC; otherwise PCPlus4In.
  - JumpTaken and BranchTaken both high: the jump wins.
- RUN IF/ID latch:
  - Jump or branch taken: flush, IFID_Valid <= 0, Instr and PCPlus4 cleared to 0. Flush overrides Stall.
  - Else Stall=1: the latch holds all fields, including Valid.
  - Else: latch InstrIn and PCPlus4In, Valid <= 1, FetchCount += 1. FetchCount wraps modulo 2^32.
- Halt detection:
  - In RUN, with no flush and no stall, InstrIn == HALT_INSTR means:
    - the halt word is latched with Valid = 1 and counted;
    - PC does not advance;
    - next state is HALTED.
  - From the following edge onward, IFID_Valid = 0.
  - A halt word present during a flush or stall is ignored that cycle.
- Latency: PC to IF/ID is one cycle. A redirect takes effect at the next edge, and its target instruction appears in IF/ID one cycle after that.
- PC arithmetic:
  - No alignment checking; targets are used verbatim.
  - PC wraps through the adder, e.g. FFFF_FFFC + 4 = 0000_0000.
- Reset mid-operation: state returns to IDLE on that edge, regardless of Stall or redirect inputs.

Optional Feature:
- Macro: IF_STEP_MODE_EN.
- Defined: adds input port Step (1 bit). In RUN, the PC and IF/ID latch update, and the flush, halt and FetchCount rules apply, only on cycles with Step=1. On cycles with Step=0 everything holds, as if Stall=1 with no redirect.
  - Redirect inputs are sampled only when Step=1.
  - Step has no effect in IDLE or HALTED.
- Undefined: the Step port does not exist and RUN advances every cycle.

Test Plan:
- Reset then Start, IMEM returning 32'h2000_0001 at every address: PCOut goes 0, 4, 8 on successive edges; IFID_Valid=1 from cycle 2; IFID_PCPlus4 = 4 then 8; FetchCount = 3 after three fetches.
- Stall=1 for 2 cycles at PC=8: PCOut stays 8, IF/ID fields unchanged, FetchCount unchanged; fetch resumes at PC=12 after Stall drops.
- BranchTaken=1 with BranchTarget=32'h40, Stall=1 and JumpTaken=0 in the same cycle: next PCOut=0x40, IFID_Valid=0; the following cycle latches the instruction at 0x40.
- JumpTaken and BranchTaken both high, JumpTarget=0x100, BranchTarget=0x40: PCOut=0x100.
- IMEM returns HALT_INSTR at 0x10: IF/ID holds FFFF_FFFF with Valid=1 for one cycle; then Halted=1, PCOut stays 0x10, Valid=0; Start is ignored; Reset restores PCOut=0 and IDLE.
- Reset asserted in RUN with a simultaneous jump: PCOut=RESET_PC, all outputs at reset values; with IF_STEP_MODE_EN defined, Step pulsed once per 3 cycles gives one PC increment per pulse.
